// File: rtl/leaky_relu_pkg.sv
// Shared defaults and data word type for the leaky ReLU blocks.
// Holds DEF_DATA_WIDTH, DEF_LEAK_SHIFT and data_t.
package leaky_relu_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LEAK_SHIFT = 2;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/sign_mask_fifo.sv
// 1-bit FIFO of forward-pass sign bits.
// Ports: push/din, pop/dout, clear, count, full, empty.
module sign_mask_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic        din,
  input  logic        pop,
  output logic        dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_en && !rd_en) begin
        count <= count + (AW+1)'(1);
      end else if (rd_en && !wr_en) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/leaky_relu_bwd.sv
// Leaky ReLU backward pass: scales gradients by stored forward signs.
// Ports: fwd/grad/out valid-ready streams, clear, mask_count.
// Option: LEAKY_RELU_BWD_ROUND_EN rounds the negative branch half up.
module leaky_relu_bwd
  import leaky_relu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int MASK_DEPTH = 16,
  localparam int CW = $clog2(MASK_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  fwd_valid,
  output logic                  fwd_ready,
  input  logic [DATA_WIDTH-1:0] fwd_x,
  input  logic                  grad_valid,
  output logic                  grad_ready,
  input  logic [DATA_WIDTH-1:0] grad_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_grad,
  output logic [CW-1:0]         mask_count
);

  logic                  push;
  logic                  pop;
  logic                  mask;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] shr;
  logic [DATA_WIDTH-1:0] leak;
  logic [DATA_WIDTH-1:0] res;

  assign fwd_ready  = ~full;
  assign grad_ready = ~empty & (~out_valid | out_ready);
  assign push       = fwd_valid & fwd_ready;
  assign pop        = grad_valid & grad_ready;

  sign_mask_fifo #(
    .DEPTH (MASK_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   (fwd_x[DATA_WIDTH-1]),
    .pop   (pop),
    .dout  (mask),
    .count (mask_count),
    .full  (full),
    .empty (empty)
  );

  assign shr = DATA_WIDTH'($signed(grad_in) >>> LEAK_SHIFT);

`ifdef LEAKY_RELU_BWD_ROUND_EN
  // Shifted magnitude is below max, so adding the dropped MSB cannot wrap.
  assign leak = shr + DATA_WIDTH'(grad_in[LEAK_SHIFT-1]);
`else
  assign leak = shr;
`endif

  assign res = mask ? leak : grad_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_grad  <= res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_leaky_relu_bwd.sv
// Directed self-checking bench for leaky_relu_bwd.
// Default parameters; honours LEAKY_RELU_BWD_ROUND_EN when defined.
module tb_leaky_relu_bwd;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        fwd_valid;
  logic        fwd_ready;
  logic [15:0] fwd_x;
  logic        grad_valid;
  logic        grad_ready;
  logic [15:0] grad_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_grad;
  logic [4:0]  mask_count;

  int n_chk;
  int n_fail;

  leaky_relu_bwd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_x      (fwd_x),
    .grad_valid (grad_valid),
    .grad_ready (grad_ready),
    .grad_in    (grad_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .mask_count (mask_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_m1;
    logic [15:0] exp_six;
    logic [15:0] bp_exp [4];
`ifdef LEAKY_RELU_BWD_ROUND_EN
    exp_m1  = 16'h0000;
    exp_six = 16'h0002;
`else
    exp_m1  = 16'hFFFF;
    exp_six = 16'h0001;
`endif
    bp_exp[0] = 16'h0100;
    bp_exp[1] = 16'h0080;
    bp_exp[2] = 16'h0300;
    bp_exp[3] = 16'h0100;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    fwd_valid = 1'b0;
    fwd_x = '0;
    grad_valid = 1'b0;
    grad_in = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_count", 32'(mask_count), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_ograd", 32'(out_grad), 0);
    chk("rst_fready", 32'(fwd_ready), 1);
    chk("rst_gready", 32'(grad_ready), 0);
    #20;
    rst_n = 1'b1;
    tick();

    // basic pair
    fwd_valid = 1'b1;
    fwd_x = 16'h0005;
    tick();
    fwd_x = 16'hFFF0;
    tick();
    fwd_valid = 1'b0;
    chk("basic_count", 32'(mask_count), 2);
    grad_valid = 1'b1;
    grad_in = 16'h0040;
    chk("basic_gready", 32'(grad_ready), 1);
    tick();
    chk("basic_v0", 32'(out_valid), 1);
    chk("basic_d0", 32'(out_grad), 32'h0040);
    grad_in = 16'hFF80;
    tick();
    chk("basic_v1", 32'(out_valid), 1);
    chk("basic_d1", 32'(out_grad), 32'hFFE0);
    grad_valid = 1'b0;
    tick();
    chk("basic_drain", 32'(out_valid), 0);
    chk("basic_empty", 32'(mask_count), 0);

    // no bypass through an empty FIFO
    fwd_valid = 1'b1;
    fwd_x = 16'h7FFF;
    grad_valid = 1'b1;
    grad_in = 16'h1234;
    chk("nobyp_gready0", 32'(grad_ready), 0);
    tick();
    fwd_valid = 1'b0;
    chk("nobyp_ovalid", 32'(out_valid), 0);
    chk("nobyp_gready1", 32'(grad_ready), 1);
    tick();
    chk("nobyp_data", 32'(out_grad), 32'h1234);
    grad_valid = 1'b0;
    tick();

    // negative branch truncation / rounding
    fwd_valid = 1'b1;
    fwd_x = 16'h8000;
    tick();
    tick();
    fwd_valid = 1'b0;
    grad_valid = 1'b1;
    grad_in = 16'hFFFF;
    tick();
    chk("neg_m1", 32'(out_grad), 32'(exp_m1));
    grad_in = 16'h0006;
    tick();
    chk("neg_six", 32'(out_grad), 32'(exp_six));
    grad_valid = 1'b0;
    tick();

    // fill to full
    fwd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fwd_x = i[0] ? (16'h8000 | 16'(i)) : 16'(i);
      tick();
    end
    chk("full_count", 32'(mask_count), 16);
    chk("full_fready", 32'(fwd_ready), 0);
    tick();
    chk("full_held", 32'(mask_count), 16);
    grad_valid = 1'b1;
    grad_in = 16'h0100;
    tick();
    chk("full_pop_cnt", 32'(mask_count), 15);
    chk("full_reenable", 32'(fwd_ready), 1);
    chk("full_pop_data", 32'(out_grad), 32'h0100);
    grad_valid = 1'b0;
    tick();
    fwd_valid = 1'b0;
    chk("full_refill", 32'(mask_count), 16);

    // backpressure
    out_ready = 1'b0;
    grad_valid = 1'b1;
    grad_in = 16'h0040;
    tick();
    chk("bp_load", 32'(out_grad), 32'h0010);
    chk("bp_gready", 32'(grad_ready), 0);
    grad_in = 16'h0080;
    tick();
    chk("bp_stable", 32'(out_grad), 32'h0010);
    chk("bp_count", 32'(mask_count), 15);
    tick();
    chk("bp_stable2", 32'(out_grad), 32'h0010);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      grad_in = 16'h0100 * 16'(k + 1);
      tick();
      chk("bp_sv", 32'(out_valid), 1);
      chk("bp_sd", 32'(out_grad), 32'(bp_exp[k]));
    end
    chk("bp_sc", 32'(mask_count), 11);

    // clear with 5 entries and pending output
    for (int k = 0; k < 6; k++) tick();
    grad_valid = 1'b0;
    out_ready = 1'b0;
    chk("clr_pre_cnt", 32'(mask_count), 5);
    chk("clr_pre_v", 32'(out_valid), 1);
    clear = 1'b1;
    fwd_valid = 1'b1;
    grad_valid = 1'b1;
    tick();
    clear = 1'b0;
    fwd_valid = 1'b0;
    chk("clr_count", 32'(mask_count), 0);
    chk("clr_ovalid", 32'(out_valid), 0);
    chk("clr_gready", 32'(grad_ready), 0);
    tick();
    chk("clr_stall", 32'(out_valid), 0);
    grad_valid = 1'b0;

    // reset mid-stream
    fwd_valid = 1'b1;
    fwd_x = 16'h8001;
    tick();
    tick();
    fwd_valid = 1'b0;
    grad_valid = 1'b1;
    grad_in = 16'h0200;
    tick();
    chk("mrst_pre", 32'(out_valid), 1);
    rst_n = 1'b0;
    #2;
    chk("mrst_count", 32'(mask_count), 0);
    chk("mrst_ovalid", 32'(out_valid), 0);
    chk("mrst_ograd", 32'(out_grad), 0);
    chk("mrst_fready", 32'(fwd_ready), 1);
    chk("mrst_gready", 32'(grad_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("mrst_stall", 32'(out_valid), 0);
    grad_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
